// File: rtl/regymm_edgecounter.sv
// regymm_edgecounter: N-channel synchronised edge counter and gated frequency meter.
// Each channel counts selected edges; latched snapshots are read one byte at a time on dout.
module regymm_edgecounter #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 14,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_CYCLES = 25000000,
  parameter int SATURATE    = 0,
  localparam int NB         = (CNT_W + 7) / 8,
  localparam int SEL_CH_W   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SEL_B_W    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                clk25,
  input  logic                rst_n,
  input  logic [NCH-1:0]      sig_in,
  input  logic [1:0]          edge_mode,
  input  logic                pause,
  input  logic                clear,
  input  logic                snap,
  input  logic                gate_en,
  input  logic [SEL_CH_W-1:0] sel_ch,
  input  logic [SEL_B_W-1:0]  sel_byte,
  output logic [7:0]          dout,
  output logic [NCH-1:0]      ovf,
  output logic                gate_done
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES + 1);

  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0]                  edgeDly_q, edgeDly_d;
  logic [NCH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0]       snapshot_q, snapshot_d;
  logic [NCH-1:0]                  ovf_q, ovf_d;
  logic [TW-1:0]                   timer_q, timer_d;
  logic [PW-1:0]                   prime_q, prime_d;
  logic                            gateDone_q, gateDone_d;
  logic [7:0]                      dout_q, dout_d;

  logic                            primed;
  logic                            gateClose;
  logic [NCH-1:0]                  syncOut;
  logic [NCH-1:0]                  evt;
  logic [NB*8-1:0]                 selWide;

  function automatic logic edgeMatch(input logic [1:0] mode, input logic cur, input logic prev);
    logic m;
    unique case (mode)
      2'b00:   m = cur & ~prev;
      2'b01:   m = ~cur & prev;
      2'b10:   m = cur ^ prev;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Events stay masked until the synchroniser has flushed its post-reset zeros.
  always_comb begin
    primed  = (prime_q == PRIME_LAST);
    prime_d = primed ? prime_q : prime_q + PW'(1);
    for (int c = 0; c < NCH; c++) begin
      sync_d[c]    = {sync_q[c][SYNC_STAGES-2:0], sig_in[c]};
      syncOut[c]   = sync_q[c][SYNC_STAGES-1];
      edgeDly_d[c] = syncOut[c];
      evt[c]       = primed & ~pause & edgeMatch(edge_mode, syncOut[c], edgeDly_q[c]);
    end
  end

  always_comb begin
    gateClose = gate_en & ~pause & (timer_q == TIMER_LAST);
    if (clear || !gate_en || gateClose) begin
      timer_d = '0;
    end else if (pause) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    gateDone_d = gateClose & ~clear;
  end

  // A gate close restarts the count with any event that coincides with it.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c]      = cnt_q[c];
      snapshot_d[c] = snapshot_q[c];
      ovf_d[c]      = ovf_q[c];
      if (clear) begin
        cnt_d[c]      = '0;
        snapshot_d[c] = '0;
        ovf_d[c]      = 1'b0;
      end else if (gateClose) begin
        snapshot_d[c] = cnt_q[c];
        cnt_d[c]      = evt[c] ? CNT_W'(1) : '0;
      end else begin
        if (snap && !gate_en) begin
          snapshot_d[c] = cnt_q[c];
        end
        if (evt[c]) begin
          if (cnt_q[c] == '1) begin
            ovf_d[c] = 1'b1;
            cnt_d[c] = (SATURATE != 0) ? cnt_q[c] : '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    dout_d  = '0;
    selWide = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_ch == SEL_CH_W'(c)) begin
        selWide[CNT_W-1:0] = snapshot_q[c];
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (sel_byte == SEL_B_W'(b)) begin
        dout_d = selWide[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      edgeDly_q  <= '0;
      cnt_q      <= '0;
      snapshot_q <= '0;
      ovf_q      <= '0;
      timer_q    <= '0;
      prime_q    <= '0;
      gateDone_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      edgeDly_q  <= edgeDly_d;
      cnt_q      <= cnt_d;
      snapshot_q <= snapshot_d;
      ovf_q      <= ovf_d;
      timer_q    <= timer_d;
      prime_q    <= prime_d;
      gateDone_q <= gateDone_d;
      dout_q     <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign gate_done = gateDone_q;

endmodule
